// File: rtl/maze_grid_memory.sv
// Maze map store: read-only wall bit per cell (MAP_INIT, bit index y*MAP_W+x) plus
// MARK_W writable mark bits per cell, swept to zero after every reset.
module maze_grid_memory #(
  parameter int MAP_W  = 17,
  parameter int MAP_H  = 17,
  parameter int X_BITS = 5,
  parameter int Y_BITS = 5,
  parameter int MARK_W = 2,
  parameter logic [MAP_W*MAP_H-1:0] MAP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic              nb_rd,
  input  logic [X_BITS-1:0] x_pos,
  input  logic [Y_BITS-1:0] y_pos,
  input  logic [MARK_W-1:0] data_in,
  output logic [MARK_W:0]   data_out,
  output logic              data_valid,
  output logic [3:0]        nbr_walls,
  output logic              nbr_valid,
  output logic              busy
);

  localparam int CELLS  = MAP_W * MAP_H;
  localparam int ADDR_W = $clog2(CELLS);

  localparam logic [X_BITS-1:0] X_LIM  = X_BITS'(MAP_W);
  localparam logic [Y_BITS-1:0] Y_LIM  = Y_BITS'(MAP_H);
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(MAP_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(MAP_H - 1);
  localparam logic [ADDR_W-1:0] ROW_A  = ADDR_W'(MAP_W);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CELLS - 1);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_NBR   = 2'd2;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] sweep_idx_reg;
  logic [X_BITS-1:0] lat_x_reg;
  logic [Y_BITS-1:0] lat_y_reg;
  logic [ADDR_W-1:0] lat_addr_reg;
  logic              lat_oor_reg;
  logic [1:0]        step_reg;
  logic [1:0]        nbr_acc_reg;

  logic [MARK_W-1:0] mark_mem [CELLS];

  logic              in_range;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [MARK_W-1:0] mem_wdata;

  logic [3:0]        nb_off;
  logic [ADDR_W-1:0] nb_addr [4];
  logic [3:0]        nb_wall;

  assign in_range = (x_pos < X_LIM) && (y_pos < Y_LIM);
  assign req_addr = ADDR_W'(y_pos) * ROW_A + ADDR_W'(x_pos);
  assign busy     = (state_reg != ST_IDLE);

  // Single write port shared by the clear sweep and mark writes (never both at once).
  assign mem_we    = (state_reg == ST_CLEAR) ||
                     ((state_reg == ST_IDLE) && wr && !rd && !nb_rd && in_range);
  assign mem_addr  = (state_reg == ST_CLEAR) ? sweep_idx_reg : req_addr;
  assign mem_wdata = (state_reg == ST_CLEAR) ? '0 : data_in;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mark_mem[mem_addr] <= mem_wdata;
    end
  end

  // Neighbour index 0..3 = N, E, S, W; off-grid neighbours (no wrap) read as wall.
  assign nb_off = {lat_x_reg == '0, lat_y_reg == Y_LAST,
                   lat_x_reg == X_LAST, lat_y_reg == '0};
  assign nb_addr[0] = lat_addr_reg - ROW_A;
  assign nb_addr[1] = lat_addr_reg + 1'b1;
  assign nb_addr[2] = lat_addr_reg + ROW_A;
  assign nb_addr[3] = lat_addr_reg - 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nb
      assign nb_wall[gi] = lat_oor_reg || nb_off[gi] || MAP_INIT[nb_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_CLEAR;
      sweep_idx_reg <= '0;
      lat_x_reg     <= '0;
      lat_y_reg     <= '0;
      lat_addr_reg  <= '0;
      lat_oor_reg   <= 1'b0;
      step_reg      <= '0;
      nbr_acc_reg   <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      nbr_walls     <= '0;
      nbr_valid     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      nbr_valid  <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (sweep_idx_reg == LAST_A) begin
            state_reg <= ST_IDLE;
          end else begin
            sweep_idx_reg <= sweep_idx_reg + 1'b1;
          end
        end
        ST_IDLE: begin
          if (nb_rd) begin
            lat_x_reg    <= x_pos;
            lat_y_reg    <= y_pos;
            lat_addr_reg <= req_addr;
            lat_oor_reg  <= !in_range;
            step_reg     <= '0;
            state_reg    <= ST_NBR;
          end else if (rd) begin
            data_out   <= in_range ? {mark_mem[req_addr], MAP_INIT[req_addr]}
                                   : {{MARK_W{1'b0}}, 1'b1};
            data_valid <= 1'b1;
          end
        end
        ST_NBR: begin
          // N and E in the first two cycles, S and W together in the result cycle.
          if (step_reg == 2'd2) begin
            nbr_walls <= {nb_wall[3], nb_wall[2], nbr_acc_reg};
            nbr_valid <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            nbr_acc_reg[step_reg[0]] <= nb_wall[step_reg];
            step_reg <= step_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
